multisim_pull_arbiter: RTL and testbench

Shares one multisim pull channel (the `data_vld`/`data`/`data_rdy` side of a pull client) among `N_REQ` local consumers. Consumers are granted exclusive ownership round-robin, for bursts of up to `MAX_BURST` words. A one-entry output register decouples the upstream handshake from the owning consumer. The block sits between a single pull client instance and the consumer logic in the client-side testbench top.

---
 rtl/multisim_pull_arbiter.sv | 120 ++++++++++++
 tb/tb_multisim_pull_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multisim_pull_arbiter.sv
// Round-robin arbiter that shares one pull-client word stream among N_REQ consumers,
// granting bursts of up to MAX_BURST words through a one-entry output register.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no owner; arbitrate among req starting at ptr
// ST_GRANT | owner holds the channel; fetch words until burst ends or req drops
module multisim_pull_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  up_vld,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  up_rdy,
    input  logic [N_REQ-1:0]      req,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      dn_vld,
    output logic [DATA_WIDTH-1:0] dn_data,
    input  logic [N_REQ-1:0]      dn_rdy
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]            state;
    logic [IDX_W-1:0]      owner;
    logic [IDX_W-1:0]      ptr;
    logic [BEAT_W-1:0]     beats;
    logic                  buf_vld;
    logic [DATA_WIDTH-1:0] buf_data;

    logic [N_REQ-1:0]      req_rot;
    logic                  pick_vld;
    logic [IDX_W-1:0]      pick_off;
    logic [IDX_W:0]        pick_sum;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      ptr_nxt;
    logic [N_REQ-1:0]      owner_oh;
    logic                  burst_done;
    logic                  accept;
    logic                  drain;
    logic                  rel;

    // Rotate so bit 0 corresponds to ptr; the lowest set bit is the next winner.
    always_comb begin
        req_rot  = N_REQ'({req, req} >> ptr);
        pick_vld = 1'b0;
        pick_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_vld = 1'b1;
                pick_off = IDX_W'(i);
            end
        end
        pick_sum = {1'b0, ptr} + {1'b0, pick_off};
        if (pick_sum >= (IDX_W + 1)'(N_REQ)) begin
            pick_idx = IDX_W'(pick_sum - (IDX_W + 1)'(N_REQ));
        end else begin
            pick_idx = IDX_W'(pick_sum);
        end
        ptr_nxt = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        burst_done      = (beats == BEAT_W'(MAX_BURST));
        up_rdy          = (state == ST_GRANT) && req[owner] && !burst_done &&
                          (!buf_vld || dn_rdy[owner]);
        accept          = up_vld && up_rdy;
        drain           = buf_vld && dn_rdy[owner];
        // Release only once nothing is left in flight for the owner.
        rel             = (state == ST_GRANT) && !accept && !(buf_vld && !drain) &&
                          (!req[owner] || burst_done);
        gnt             = (state == ST_GRANT) ? owner_oh : '0;
        dn_vld          = ((state == ST_GRANT) && buf_vld) ? owner_oh : '0;
        dn_data         = buf_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= '0;
            beats    <= '0;
            buf_vld  <= 1'b0;
            buf_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        owner <= pick_idx;
                        beats <= '0;
                        ptr   <= ptr_nxt;
                        state <= ST_GRANT;
                    end
                end
                default: begin
                    if (accept) begin
                        buf_data <= up_data;
                        buf_vld  <= 1'b1;
                        beats    <= beats + 1'b1;
                    end else if (drain) begin
                        buf_vld <= 1'b0;
                    end
                    if (rel) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multisim_pull_arbiter.sv
// Directed bench for multisim_pull_arbiter: three instances (MAX_BURST 4, 1, 2) share
// stimulus; each step checks the selected instance against hand-computed values.
module tb_multisim_pull_arbiter;

    logic        clk;
    logic        rst_n;
    logic        up_vld;
    logic [63:0] up_data;
    logic [3:0]  req;
    logic [3:0]  dn_rdy;

    logic        up_rdy_0, up_rdy_1, up_rdy_2;
    logic [3:0]  gnt_0, gnt_1, gnt_2;
    logic [3:0]  dn_vld_0, dn_vld_1, dn_vld_2;
    logic [63:0] dn_data_0, dn_data_1, dn_data_2;

    logic        cur_up_rdy;
    logic [3:0]  cur_gnt;
    logic [3:0]  cur_dn_vld;
    logic [63:0] cur_dn_data;

    int          sel;
    int          n_cmp;
    int          n_mis;
    logic [63:0] wq [16];
    int          wi;
    int          wn;

    multisim_pull_arbiter #(.DATA_WIDTH(64), .N_REQ(4), .MAX_BURST(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .up_vld(up_vld), .up_data(up_data), .up_rdy(up_rdy_0),
        .req(req), .gnt(gnt_0), .dn_vld(dn_vld_0), .dn_data(dn_data_0), .dn_rdy(dn_rdy));

    multisim_pull_arbiter #(.DATA_WIDTH(64), .N_REQ(4), .MAX_BURST(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .up_vld(up_vld), .up_data(up_data), .up_rdy(up_rdy_1),
        .req(req), .gnt(gnt_1), .dn_vld(dn_vld_1), .dn_data(dn_data_1), .dn_rdy(dn_rdy));

    multisim_pull_arbiter #(.DATA_WIDTH(64), .N_REQ(4), .MAX_BURST(2)) u_b2 (
        .clk(clk), .rst_n(rst_n), .up_vld(up_vld), .up_data(up_data), .up_rdy(up_rdy_2),
        .req(req), .gnt(gnt_2), .dn_vld(dn_vld_2), .dn_data(dn_data_2), .dn_rdy(dn_rdy));

    always_comb begin
        case (sel)
            1: begin
                cur_up_rdy = up_rdy_1; cur_gnt = gnt_1;
                cur_dn_vld = dn_vld_1; cur_dn_data = dn_data_1;
            end
            2: begin
                cur_up_rdy = up_rdy_2; cur_gnt = gnt_2;
                cur_dn_vld = dn_vld_2; cur_dn_data = dn_data_2;
            end
            default: begin
                cur_up_rdy = up_rdy_0; cur_gnt = gnt_0;
                cur_dn_vld = dn_vld_0; cur_dn_data = dn_data_0;
            end
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] v,
                           input logic [63:0] d, input logic r);
        chk({tag, ".gnt"}, {60'd0, cur_gnt}, {60'd0, g});
        chk({tag, ".dn_vld"}, {60'd0, cur_dn_vld}, {60'd0, v});
        chk({tag, ".dn_data"}, cur_dn_data, d);
        chk({tag, ".up_rdy"}, {63'd0, cur_up_rdy}, {63'd0, r});
    endtask

    // One clock: note whether the selected instance accepts, then advance the word source.
    task automatic tick();
        logic acc;
        #1;
        acc = up_vld && cur_up_rdy;
        @(posedge clk);
        #1;
        if (acc) begin
            wi++;
            if (wi < wn) up_data = wq[wi];
            else up_vld = 1'b0;
        end
    endtask

    task automatic load(input logic [63:0] first, input int n);
        for (int i = 0; i < 16; i++) wq[i] = first + 64'(i);
        wi      = 0;
        wn      = n;
        up_data = wq[0];
        up_vld  = 1'b1;
    endtask

    task automatic do_reset(input int s);
        sel     = s;
        rst_n   = 1'b0;
        req     = '0;
        dn_rdy  = '0;
        up_vld  = 1'b0;
        up_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        sel   = 0;
        wi    = 0;
        wn    = 0;
        rst_n   = 1'b0;
        req     = '0;
        dn_rdy  = '0;
        up_vld  = 1'b0;
        up_data = '0;
        #3;
        chk_out("reset", 4'b0000, 4'b0000, 64'h0, 1'b0);

        // Single consumer burst, MAX_BURST=4
        do_reset(0);
        req = 4'b0010; dn_rdy = 4'b0010;
        load(64'hA0, 6);
        tick(); chk_out("burst.grant", 4'b0010, 4'b0000, 64'h0, 1'b1);
        tick(); chk_out("burst.w0", 4'b0010, 4'b0010, 64'hA0, 1'b1);
        tick(); chk_out("burst.w1", 4'b0010, 4'b0010, 64'hA1, 1'b1);
        tick(); chk_out("burst.w2", 4'b0010, 4'b0010, 64'hA2, 1'b1);
        tick(); chk_out("burst.w3", 4'b0010, 4'b0010, 64'hA3, 1'b0);
        tick(); chk_out("burst.idle", 4'b0000, 4'b0000, 64'hA3, 1'b0);
        tick(); chk_out("burst.regrant", 4'b0010, 4'b0000, 64'hA3, 1'b1);
        tick(); chk_out("burst.w4", 4'b0010, 4'b0010, 64'hA4, 1'b1);
        tick(); chk_out("burst.w5", 4'b0010, 4'b0010, 64'hA5, 1'b1);
        tick(); chk_out("burst.empty", 4'b0010, 4'b0000, 64'hA5, 1'b1);
        req = 4'b0000;
        tick(); chk_out("burst.drop", 4'b0000, 4'b0000, 64'hA5, 1'b0);

        // Round-robin fairness, MAX_BURST=1
        do_reset(1);
        req = 4'b1111; dn_rdy = 4'b1111;
        load(64'h10, 8);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (k % 4);
            tick(); chk_out("rr.grant", oh, 4'b0000, (k == 0) ? 64'h0 : 64'h10 + 64'(k - 1), 1'b1);
            tick(); chk_out("rr.word", oh, oh, 64'h10 + 64'(k), 1'b0);
            tick(); chk_out("rr.idle", 4'b0000, 4'b0000, 64'h10 + 64'(k), 1'b0);
        end

        // Backpressure on owner 2
        do_reset(0);
        req = 4'b0100; dn_rdy = 4'b0000;
        load(64'h11, 3);
        tick(); chk_out("bp.grant", 4'b0100, 4'b0000, 64'h0, 1'b1);
        tick(); chk_out("bp.w0", 4'b0100, 4'b0100, 64'h11, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(); chk_out("bp.hold", 4'b0100, 4'b0100, 64'h11, 1'b0);
        end
        dn_rdy = 4'b0100;
        #1;
        chk("bp.rdy_release", {63'd0, cur_up_rdy}, 64'h1);
        tick(); chk_out("bp.w1", 4'b0100, 4'b0100, 64'h12, 1'b1);
        req = 4'b0000;
        tick(); chk_out("bp.end", 4'b0000, 4'b0000, 64'h12, 1'b0);

        // Request drop with a pending word
        do_reset(0);
        req = 4'b0001; dn_rdy = 4'b0000;
        load(64'h55, 2);
        tick(); chk_out("drop.grant", 4'b0001, 4'b0000, 64'h0, 1'b1);
        tick();
        req = 4'b0000;
        chk_out("drop.c1", 4'b0001, 4'b0001, 64'h55, 1'b0);
        tick(); chk_out("drop.c2", 4'b0001, 4'b0001, 64'h55, 1'b0);
        tick(); chk_out("drop.c3", 4'b0001, 4'b0001, 64'h55, 1'b0);
        dn_rdy = 4'b0001;
        tick(); chk_out("drop.drain", 4'b0000, 4'b0000, 64'h55, 1'b0);
        chk("drop.no_fetch", 64'(wi), 64'd1);

        // Sparse upstream, MAX_BURST=2
        do_reset(2);
        req = 4'b0001; dn_rdy = 4'b0001;
        load(64'h1, 2);
        up_vld = 1'b0;
        tick(); chk_out("sparse.grant", 4'b0001, 4'b0000, 64'h0, 1'b1);
        up_vld = 1'b1;
        tick(); chk_out("sparse.w0", 4'b0001, 4'b0001, 64'h1, 1'b1);
        up_vld = 1'b0;
        tick(); chk_out("sparse.gap", 4'b0001, 4'b0000, 64'h1, 1'b1);
        up_vld = 1'b1;
        tick(); chk_out("sparse.w1", 4'b0001, 4'b0001, 64'h2, 1'b0);
        tick(); chk_out("sparse.rel", 4'b0000, 4'b0000, 64'h2, 1'b0);

        // Asynchronous reset with a word buffered
        do_reset(0);
        req = 4'b0010; dn_rdy = 4'b0000;
        load(64'h77, 1);
        tick(); chk_out("arst.grant", 4'b0010, 4'b0000, 64'h0, 1'b1);
        tick(); chk_out("arst.word", 4'b0010, 4'b0010, 64'h77, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst.async", 4'b0000, 4'b0000, 64'h0, 1'b0);
        req = 4'b1001; dn_rdy = 4'b1001; up_vld = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(); chk_out("arst.rearb", 4'b0001, 4'b0000, 64'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
